// File: rtl/dmem_pkg.sv
// Shared types for the dmem port arbiter: requester ids, decode kinds and the
// response tag carried down the read-latency pipe.
package dmem_pkg;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_VID = 1'b1
  } owner_e;

  typedef enum logic [1:0] {
    K_MEM  = 2'd0,
    K_MMIO = 2'd1,
    K_OOR  = 2'd2
  } kind_e;

  localparam int unsigned MMIO_SW_ADDR = 256;

  typedef struct packed {
    logic       valid;
    owner_e     owner;
    kind_e      kind;
    logic [1:0] mmio_data;
  } rsp_tag_t;

  // Switch code 11 is reserved and reads as 0.
  function automatic logic [1:0] sw_code(input logic [1:0] raw);
    return (raw == 2'b11) ? 2'b00 : raw;
  endfunction

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Requester and ROM-side signals of the dmem port arbiter.
interface dmem_port_arbiter_if #(
  parameter int unsigned AW = 8
) ();

  logic          cpu_req;
  logic [31:0]   cpu_addr;
  logic          cpu_gnt;
  logic          cpu_rvalid;
  logic [31:0]   cpu_rdata;

  logic          vid_req;
  logic [31:0]   vid_addr;
  logic          vid_gnt;
  logic          vid_rvalid;
  logic [31:0]   vid_rdata;

  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_q;

  // Arbiter side.
  modport slave (
    input  cpu_req, cpu_addr, vid_req, vid_addr, mem_q,
    output cpu_gnt, cpu_rvalid, cpu_rdata, vid_gnt, vid_rvalid, vid_rdata, mem_addr
  );

  // Requesters plus ROM side.
  modport master (
    output cpu_req, cpu_addr, vid_req, vid_addr, mem_q,
    input  cpu_gnt, cpu_rvalid, cpu_rdata, vid_gnt, vid_rvalid, vid_rdata, mem_addr
  );

endinterface

// File: rtl/dmem_rsp_pipe.sv
// Fixed-depth delay line for response tags; cleared asynchronously so that
// grants made before a reset never produce a response.
module dmem_rsp_pipe
  import dmem_pkg::*;
#(
  parameter int unsigned Depth = 1
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  rsp_tag_t tag_i,
  output rsp_tag_t tag_o
);

  rsp_tag_t stage_q [Depth];
  rsp_tag_t stage_d [Depth];

  always_comb begin
    stage_d[0] = tag_i;
    for (int i = 1; i < int'(Depth); i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Depth); i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(Depth); i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign tag_o = stage_q[Depth-1];

endmodule

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing the data ROM between the CPU load port and the
// video fetcher, with a switch MMIO word and fixed-latency in-order responses.
module dmem_port_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned AW      = 8,
  parameter int unsigned RD_LAT  = 1,
  parameter int unsigned MMIO_SW = MMIO_SW_ADDR
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                switch1,
  input  logic                switch2,
  dmem_port_arbiter_if.slave  bus
);

  localparam logic [32:0] MEM_BYTES = 33'd4 << AW;

  logic [1:0]    sw_meta_q, sw_sync_q;
  owner_e        last_owner_q, last_owner_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]   cpu_rdata_q, cpu_rdata_d;
  logic [31:0]   vid_rdata_q, vid_rdata_d;

  logic          cpu_win, vid_win, gnt_any;
  logic [31:0]   gnt_addr;
  kind_e         gnt_kind;
  rsp_tag_t      tag_in, tag_out;
  logic [31:0]   rsp_data;
  logic          cpu_rvalid, vid_rvalid;

  // Arbitration and decode of the granted address.
  always_comb begin
    cpu_win  = bus.cpu_req && (!bus.vid_req || (last_owner_q == OWN_VID));
    vid_win  = bus.vid_req && !cpu_win;
    gnt_any  = cpu_win || vid_win;
    gnt_addr = cpu_win ? bus.cpu_addr : bus.vid_addr;

    // The switch word lies inside the ROM window, so it is matched first.
    if (gnt_addr == MMIO_SW) begin
      gnt_kind = K_MMIO;
    end else if ({1'b0, gnt_addr} < MEM_BYTES) begin
      gnt_kind = K_MEM;
    end else begin
      gnt_kind = K_OOR;
    end

    last_owner_d = last_owner_q;
    if (cpu_win) begin
      last_owner_d = OWN_CPU;
    end else if (vid_win) begin
      last_owner_d = OWN_VID;
    end

    mem_addr_d = gnt_any ? gnt_addr[AW+1:2] : mem_addr_q;

    tag_in.valid     = gnt_any;
    tag_in.owner     = vid_win ? OWN_VID : OWN_CPU;
    tag_in.kind      = gnt_kind;
    tag_in.mmio_data = sw_code(sw_sync_q);
  end

  dmem_rsp_pipe #(
    .Depth (RD_LAT)
  ) u_rsp_pipe (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .tag_i  (tag_in),
    .tag_o  (tag_out)
  );

  // Response mux; the requester not being answered keeps its last data.
  always_comb begin
    unique case (tag_out.kind)
      K_MEM:   rsp_data = bus.mem_q;
      K_MMIO:  rsp_data = {30'b0, tag_out.mmio_data};
      default: rsp_data = 32'b0;
    endcase

    cpu_rvalid  = tag_out.valid && (tag_out.owner == OWN_CPU);
    vid_rvalid  = tag_out.valid && (tag_out.owner == OWN_VID);
    cpu_rdata_d = cpu_rvalid ? rsp_data : cpu_rdata_q;
    vid_rdata_d = vid_rvalid ? rsp_data : vid_rdata_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sw_meta_q    <= 2'b00;
      sw_sync_q    <= 2'b00;
      last_owner_q <= OWN_VID;
      mem_addr_q   <= '0;
      cpu_rdata_q  <= 32'b0;
      vid_rdata_q  <= 32'b0;
    end else begin
      sw_meta_q    <= {switch1, switch2};
      sw_sync_q    <= sw_meta_q;
      last_owner_q <= last_owner_d;
      mem_addr_q   <= mem_addr_d;
      cpu_rdata_q  <= cpu_rdata_d;
      vid_rdata_q  <= vid_rdata_d;
    end
  end

  assign bus.cpu_gnt    = cpu_win;
  assign bus.vid_gnt    = vid_win;
  assign bus.cpu_rvalid = cpu_rvalid;
  assign bus.vid_rvalid = vid_rvalid;
  assign bus.cpu_rdata  = cpu_rdata_d;
  assign bus.vid_rdata  = vid_rdata_d;
  assign bus.mem_addr   = mem_addr_d;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench: drives identical traffic into RD_LAT=1 and RD_LAT=2 instances
// and checks grants, mem_addr, rvalid timing and rdata against hand values.
module tb_dmem_port_arbiter;

  localparam int NCYC = 160;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n = 1'b0;
  logic        switch1 = 1'b0;
  logic        switch2 = 1'b0;
  logic        cpu_req = 1'b0;
  logic [31:0] cpu_addr = 32'h0;
  logic        vid_req = 1'b0;
  logic [31:0] vid_addr = 32'h0;

  dmem_port_arbiter_if #(.AW(8)) bus1 ();
  dmem_port_arbiter_if #(.AW(8)) bus2 ();

  assign bus1.cpu_req  = cpu_req;
  assign bus1.cpu_addr = cpu_addr;
  assign bus1.vid_req  = vid_req;
  assign bus1.vid_addr = vid_addr;
  assign bus2.cpu_req  = cpu_req;
  assign bus2.cpu_addr = cpu_addr;
  assign bus2.vid_req  = vid_req;
  assign bus2.vid_addr = vid_addr;

  dmem_port_arbiter #(.AW(8), .RD_LAT(1), .MMIO_SW(256)) u_dut1 (
    .clk     (clk),
    .reset_n (reset_n),
    .switch1 (switch1),
    .switch2 (switch2),
    .bus     (bus1)
  );

  dmem_port_arbiter #(.AW(8), .RD_LAT(2), .MMIO_SW(256)) u_dut2 (
    .clk     (clk),
    .reset_n (reset_n),
    .switch1 (switch1),
    .switch2 (switch2),
    .bus     (bus2)
  );

  // ROM contents: word 4 = DEADBEEF, otherwise 0x123400<word>.
  function automatic logic [31:0] rom_word(input logic [7:0] a);
    return (a == 8'd4) ? 32'hDEADBEEF : {24'h123400, a};
  endfunction

  logic [31:0] q1 = 32'h0, q2a = 32'h0, q2 = 32'h0;
  always @(posedge clk) begin
    q1  <= rom_word(bus1.mem_addr);
    q2a <= rom_word(bus2.mem_addr);
    q2  <= q2a;
  end
  assign bus1.mem_q = q1;
  assign bus2.mem_q = q2;

  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  bit          ev_cpu [2][NCYC];
  bit          ev_vid [2][NCYC];
  logic [31:0] ed_cpu [2][NCYC];
  logic [31:0] ed_vid [2][NCYC];
  logic [31:0] last_cpu [2];
  logic [31:0] last_vid [2];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic check_outputs(input logic ecg, input logic evg, input int ema);
    for (int d = 0; d < 2; d++) begin
      logic        g_cg, g_vg, g_cv, g_vv;
      logic [7:0]  g_ma;
      logic [31:0] g_cd, g_vd;
      g_cg = (d == 0) ? bus1.cpu_gnt    : bus2.cpu_gnt;
      g_vg = (d == 0) ? bus1.vid_gnt    : bus2.vid_gnt;
      g_cv = (d == 0) ? bus1.cpu_rvalid : bus2.cpu_rvalid;
      g_vv = (d == 0) ? bus1.vid_rvalid : bus2.vid_rvalid;
      g_ma = (d == 0) ? bus1.mem_addr   : bus2.mem_addr;
      g_cd = (d == 0) ? bus1.cpu_rdata  : bus2.cpu_rdata;
      g_vd = (d == 0) ? bus1.vid_rdata  : bus2.vid_rdata;
      check_val($sformatf("lat%0d cpu_gnt", d + 1), {31'b0, g_cg}, {31'b0, ecg});
      check_val($sformatf("lat%0d vid_gnt", d + 1), {31'b0, g_vg}, {31'b0, evg});
      if (ema >= 0) check_val($sformatf("lat%0d mem_addr", d + 1), {24'b0, g_ma}, ema);
      if (ev_cpu[d][cyc]) last_cpu[d] = ed_cpu[d][cyc];
      if (ev_vid[d][cyc]) last_vid[d] = ed_vid[d][cyc];
      check_val($sformatf("lat%0d cpu_rvalid", d + 1), {31'b0, g_cv}, {31'b0, ev_cpu[d][cyc]});
      check_val($sformatf("lat%0d vid_rvalid", d + 1), {31'b0, g_vv}, {31'b0, ev_vid[d][cyc]});
      check_val($sformatf("lat%0d cpu_rdata", d + 1), g_cd, last_cpu[d]);
      check_val($sformatf("lat%0d vid_rdata", d + 1), g_vd, last_vid[d]);
    end
  endtask

  // Called at a falling edge; drives one cycle, checks it, advances to the next.
  task automatic step(input logic cr, input logic [31:0] ca, input logic vr,
                      input logic [31:0] va, input logic ecg, input logic evg,
                      input logic [31:0] ecd, input logic [31:0] evd, input int ema);
    cpu_req  = cr;
    cpu_addr = ca;
    vid_req  = vr;
    vid_addr = va;
    #1;
    check_outputs(ecg, evg, ema);
    for (int d = 0; d < 2; d++) begin
      if (ecg) begin
        ev_cpu[d][cyc+d+1] = 1'b1;
        ed_cpu[d][cyc+d+1] = ecd;
      end
      if (evg) begin
        ev_vid[d][cyc+d+1] = 1'b1;
        ed_vid[d][cyc+d+1] = evd;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, -1);
  endtask

  task automatic cpu_rd(input logic [31:0] a, input logic [31:0] data, input int ema);
    step(1'b1, a, 1'b0, 32'h0, 1'b1, 1'b0, data, 32'h0, ema);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    cpu_req = 1'b0;
    vid_req = 1'b0;
    for (int d = 0; d < 2; d++) begin
      for (int i = cyc; i < NCYC; i++) begin
        ev_cpu[d][i] = 1'b0;
        ev_vid[d][i] = 1'b0;
      end
      last_cpu[d] = 32'h0;
      last_vid[d] = 32'h0;
    end
    #1;
    check_outputs(1'b0, 1'b0, 0);
    cyc++;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // Both requesting: CPU first after reset, then strict alternation.
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 32'h10, 1'b1, 32'h20, 1'b1, 1'b0, 32'hDEADBEEF, 32'h0, 4);
      step(1'b1, 32'h10, 1'b1, 32'h20, 1'b0, 1'b1, 32'h0, 32'h12340008, 8);
    end
    idle(2);

    // Address boundaries: last ROM word, first OOR word, unaligned, 257 is ROM.
    cpu_rd(32'h3FC, 32'h123400FF, 255);
    step(1'b0, 32'h0, 1'b1, 32'h400, 1'b0, 1'b1, 32'h0, 32'h0, -1);
    cpu_rd(32'h101, 32'h12340040, 64);
    cpu_rd(32'h10, 32'hDEADBEEF, 4);
    cpu_rd(32'h0F, 32'h12340003, 3);
    idle(2);

    // Back-to-back VID MEM, VID OOR, CPU MEM keep grant order.
    step(1'b0, 32'h0, 1'b1, 32'h24, 1'b0, 1'b1, 32'h0, 32'h12340009, 9);
    step(1'b0, 32'h0, 1'b1, 32'h100000, 1'b0, 1'b1, 32'h0, 32'h0, -1);
    cpu_rd(32'h8, 32'h12340002, 2);
    idle(2);

    // Switch MMIO: code 10 -> 2, 11 -> 0, then sync delay on 10 -> 01.
    switch1 = 1'b1; switch2 = 1'b0;
    idle(3);
    cpu_rd(32'd256, 32'd2, 64);
    switch1 = 1'b1; switch2 = 1'b1;
    idle(3);
    cpu_rd(32'd256, 32'd0, 64);
    switch1 = 1'b1; switch2 = 1'b0;
    idle(3);
    cpu_rd(32'd256, 32'd2, 64);
    switch1 = 1'b0; switch2 = 1'b1;
    cpu_rd(32'd256, 32'd2, 64);
    cpu_rd(32'd256, 32'd2, 64);
    cpu_rd(32'd256, 32'd1, 64);
    idle(2);

    // Reset inside the latency window drops the response and rearms the tie.
    cpu_rd(32'h10, 32'hDEADBEEF, 4);
    do_reset();
    step(1'b1, 32'h8, 1'b1, 32'h24, 1'b1, 1'b0, 32'h12340002, 32'h0, 2);
    step(1'b1, 32'h8, 1'b1, 32'h24, 1'b0, 1'b1, 32'h0, 32'h12340009, 9);
    idle(3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
